mem_arbiter: RTL and testbench

//   Shares the single external memory bus between instruction fetch and the data (load/store) port.

---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares the external memory bus between instruction fetch and the data port.
// Data has priority; a streak counter stops data from starving fetch.
module mem_arbiter #(
    parameter int MAX_DATA_STREAK = 4,
    parameter int STREAK_WIDTH    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_ready,
    output logic [31:0] fetch_data,
    input  logic        mem_req,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_strb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        ext_valid,
    output logic        ext_write,
    output logic [31:0] ext_addr,
    output logic [31:0] ext_wdata,
    output logic [3:0]  ext_strb,
    input  logic        ext_ready,
    input  logic [31:0] ext_rdata
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_BUS_FETCH = 2'd1;
    localparam logic [1:0] S_BUS_MEM   = 2'd2;
    localparam logic [1:0] S_RESP      = 2'd3;

    localparam logic [STREAK_WIDTH-1:0] STREAK_MAX =
        STREAK_WIDTH'(MAX_DATA_STREAK);

    logic [1:0]              state_q, state_d;
    logic [STREAK_WIDTH-1:0] streak_q, streak_d;
    logic                    ext_valid_q, ext_valid_d;
    logic                    ext_write_q, ext_write_d;
    logic [31:0]             ext_addr_q, ext_addr_d;
    logic [31:0]             ext_wdata_q, ext_wdata_d;
    logic [3:0]              ext_strb_q, ext_strb_d;
    logic                    fetch_ready_q, fetch_ready_d;
    logic                    mem_ready_q, mem_ready_d;
    logic [31:0]             fetch_data_q, fetch_data_d;
    logic [31:0]             mem_rdata_q, mem_rdata_d;
    logic                    fetch_forced;
    logic                    bus_done;

    assign fetch_forced = fetch_req && (streak_q == STREAK_MAX);
    assign bus_done     = ext_valid_q && ext_ready;

    always_comb begin
        state_d       = state_q;
        streak_d      = streak_q;
        ext_valid_d   = ext_valid_q;
        ext_write_d   = ext_write_q;
        ext_addr_d    = ext_addr_q;
        ext_wdata_d   = ext_wdata_q;
        ext_strb_d    = ext_strb_q;
        fetch_ready_d = 1'b0;
        mem_ready_d   = 1'b0;
        fetch_data_d  = fetch_data_q;
        mem_rdata_d   = mem_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (mem_req && !fetch_forced) begin
                    state_d     = S_BUS_MEM;
                    ext_valid_d = 1'b1;
                    ext_write_d = mem_write;
                    ext_addr_d  = mem_addr;
                    ext_wdata_d = mem_wdata;
                    ext_strb_d  = mem_write ? mem_strb : 4'b0000;
                    if (!fetch_req) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (fetch_req) begin
                    state_d     = S_BUS_FETCH;
                    ext_valid_d = 1'b1;
                    ext_write_d = 1'b0;
                    ext_addr_d  = fetch_addr;
                    ext_wdata_d = 32'h0;
                    ext_strb_d  = 4'b0000;
                    streak_d    = '0;
                end
            end
            S_BUS_FETCH: begin
                if (bus_done) begin
                    state_d       = S_RESP;
                    ext_valid_d   = 1'b0;
                    fetch_data_d  = ext_rdata;
                    // a redirected fetch lets the bus finish but gets no pulse
                    fetch_ready_d = fetch_req;
                end
            end
            S_BUS_MEM: begin
                if (bus_done) begin
                    state_d     = S_RESP;
                    ext_valid_d = 1'b0;
                    mem_ready_d = mem_req;
                    if (!ext_write_q) begin
                        mem_rdata_d = ext_rdata;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            streak_q      <= '0;
            ext_valid_q   <= 1'b0;
            ext_write_q   <= 1'b0;
            ext_addr_q    <= 32'h0;
            ext_wdata_q   <= 32'h0;
            ext_strb_q    <= 4'b0000;
            fetch_ready_q <= 1'b0;
            mem_ready_q   <= 1'b0;
            fetch_data_q  <= 32'h0;
            mem_rdata_q   <= 32'h0;
        end else begin
            state_q       <= state_d;
            streak_q      <= streak_d;
            ext_valid_q   <= ext_valid_d;
            ext_write_q   <= ext_write_d;
            ext_addr_q    <= ext_addr_d;
            ext_wdata_q   <= ext_wdata_d;
            ext_strb_q    <= ext_strb_d;
            fetch_ready_q <= fetch_ready_d;
            mem_ready_q   <= mem_ready_d;
            fetch_data_q  <= fetch_data_d;
            mem_rdata_q   <= mem_rdata_d;
        end
    end

    assign ext_valid   = ext_valid_q;
    assign ext_write   = ext_write_q;
    assign ext_addr    = ext_addr_q;
    assign ext_wdata   = ext_wdata_q;
    assign ext_strb    = ext_strb_q;
    assign fetch_ready = fetch_ready_q;
    assign mem_ready   = mem_ready_q;
    assign fetch_data  = fetch_data_q;
    assign mem_rdata   = mem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: queued bus and response expectations,
// autonomous requesters and a bus responder with programmable wait states.
module tb_mem_arbiter;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } bus_t;

    typedef struct {
        bit          is_fetch;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic        mem_req;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_strb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        ext_valid;
    logic        ext_write;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic [3:0]  ext_strb;
    logic        ext_ready;
    logic [31:0] ext_rdata;

    logic [31:0] fq[$];
    bus_t        mq[$];
    bus_t        bq[$];
    resp_t       rq[$];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int hs_cyc = -10;
    int bus_wait = 0;
    int bcnt = 0;
    bit abandon_fetch = 0;
    logic [31:0] exp_last_load = 32'h0;

    mem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ready(fetch_ready),
        .fetch_data (fetch_data),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_strb   (mem_strb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .ext_valid  (ext_valid),
        .ext_write  (ext_write),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_strb   (ext_strb),
        .ext_ready  (ext_ready),
        .ext_rdata  (ext_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] bus_data(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return a ^ 32'hC0DE_0000;
    endfunction

    // requesters: hold req until the ready pulse (or an abandon)
    initial begin
        logic [31:0] dummy_a;
        bus_t        dummy_b;
        fetch_req = 0; fetch_addr = 0;
        mem_req = 0; mem_write = 0; mem_addr = 0; mem_wdata = 0; mem_strb = 0;
        forever begin
            @(posedge clk); #1;
            if (fetch_ready && fq.size() > 0) dummy_a = fq.pop_front();
            if (abandon_fetch) begin
                if (fq.size() > 0) dummy_a = fq.pop_front();
                abandon_fetch = 0;
            end
            if (mem_ready && mq.size() > 0) dummy_b = mq.pop_front();
            fetch_req = fq.size() > 0;
            if (fq.size() > 0) fetch_addr = fq[0];
            mem_req = mq.size() > 0;
            if (mq.size() > 0) begin
                mem_write = mq[0].wr;
                mem_addr  = mq[0].addr;
                mem_wdata = mq[0].wdata;
                mem_strb  = mq[0].strb;
            end
        end
    end

    // bus slave: ext_ready after bus_wait stalled cycles
    initial begin
        ext_ready = 0; ext_rdata = 0;
        forever begin
            @(posedge clk); #1;
            if (ext_valid && !reset) begin
                if (bcnt >= bus_wait) begin
                    ext_ready = 1;
                    ext_rdata = bus_data(ext_addr);
                end else begin
                    bcnt = bcnt + 1;
                    ext_ready = 0;
                end
            end else begin
                ext_ready = 0;
                bcnt = 0;
            end
        end
    end

    // bus monitor: every valid cycle must match the expected transaction
    always @(negedge clk) begin
        if (reset === 1'b0 && ext_valid === 1'b1) begin
            if (bq.size() == 0) begin
                check("bus_unexpected", 32'(ext_valid), 32'h0);
            end else begin
                check("bus_addr", ext_addr, bq[0].addr);
                check("bus_write", 32'(ext_write), 32'(bq[0].wr));
                check("bus_strb", 32'(ext_strb), 32'(bq[0].strb));
                if (bq[0].wr) check("bus_wdata", ext_wdata, bq[0].wdata);
                if (ext_ready) begin
                    hs_cyc = cyc;
                    void'(bq.pop_front());
                end
            end
        end
    end

    // response monitor
    always @(negedge clk) begin
        resp_t e;
        if (reset === 1'b0) begin
            if (fetch_ready === 1'b1 && mem_ready === 1'b1)
                check("both_ready", 32'h1, 32'h0);
            if (fetch_ready === 1'b1 || mem_ready === 1'b1) begin
                if (rq.size() == 0) begin
                    check("ready_unexpected", 32'(fetch_ready), 32'(mem_ready));
                    check("ready_unexpected_any", 32'h1, 32'h0);
                end else begin
                    e = rq.pop_front();
                    check("resp_port", 32'(fetch_ready), 32'(e.is_fetch));
                    check("resp_data", e.is_fetch ? fetch_data : mem_rdata,
                          e.data);
                    check("resp_latency", 32'(cyc), 32'(hs_cyc + 1));
                end
            end
        end
    end

    task automatic wait_done(input string name);
        bit done = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (fq.size() == 0 && mq.size() == 0 && bq.size() == 0 &&
                rq.size() == 0 && !ext_valid) begin
                done = 1;
                break;
            end
        end
        check(name, 32'(done), 32'h1);
        repeat (3) @(negedge clk);
    endtask

    function automatic bus_t mk(input bit wr, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] s);
        bus_t b;
        b.wr = wr; b.addr = a; b.wdata = d; b.strb = s;
        return b;
    endfunction

    function automatic resp_t rs(input bit f, input logic [31:0] d);
        resp_t r;
        r.is_fetch = f; r.data = d;
        return r;
    endfunction

    initial begin
        bit seen;
        reset = 1;
        repeat (3) @(negedge clk);
        check("rst_ext_valid", 32'(ext_valid), 32'h0);
        check("rst_ext_write", 32'(ext_write), 32'h0);
        check("rst_ext_strb", 32'(ext_strb), 32'h0);
        check("rst_ext_addr", ext_addr, 32'h0);
        check("rst_ext_wdata", ext_wdata, 32'h0);
        check("rst_readys", {30'h0, fetch_ready, mem_ready}, 32'h0);
        check("rst_fetch_data", fetch_data, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        reset = 0;
        @(negedge clk);

        // single fetch, zero-wait bus
        bus_wait = 0;
        bq.push_back(mk(0, 32'h100, 32'h0, 4'h0));
        rq.push_back(rs(1, 32'h0000_0013));
        fq.push_back(32'h100);
        wait_done("t1_done");

        // simultaneous fetch and load: data first
        bq.push_back(mk(0, 32'h2000, 32'h0, 4'h0));
        bq.push_back(mk(0, 32'h400, 32'h0, 4'h0));
        rq.push_back(rs(0, 32'hC0DE_2000));
        rq.push_back(rs(1, 32'hC0DE_0400));
        exp_last_load = 32'hC0DE_2000;
        mq.push_back(mk(0, 32'h2000, 32'h0, 4'h0));
        fq.push_back(32'h400);
        wait_done("t2_done");

        // streak guard: 4 stores, 1 fetch, then data resumes
        for (int i = 0; i < 4; i++) begin
            bq.push_back(mk(1, 32'h3000 + 32'(4 * i), 32'h1111_0000 + 32'(i), 4'hF));
            rq.push_back(rs(0, exp_last_load));
        end
        bq.push_back(mk(0, 32'h200, 32'h0, 4'h0));
        rq.push_back(rs(1, 32'hC0DE_0200));
        for (int i = 4; i < 6; i++) begin
            bq.push_back(mk(1, 32'h3000 + 32'(4 * i), 32'h1111_0000 + 32'(i), 4'hF));
            rq.push_back(rs(0, exp_last_load));
        end
        for (int i = 0; i < 6; i++)
            mq.push_back(mk(1, 32'h3000 + 32'(4 * i), 32'h1111_0000 + 32'(i), 4'hF));
        fq.push_back(32'h200);
        wait_done("t3_done");

        // stalled store: ext_* stable for 5 wait cycles
        bus_wait = 5;
        bq.push_back(mk(1, 32'h5000, 32'hDEAD_BEEF, 4'b0011));
        rq.push_back(rs(0, exp_last_load));
        mq.push_back(mk(1, 32'h5000, 32'hDEAD_BEEF, 4'b0011));
        wait_done("t4_done");

        // abandoned fetch: bus completes, no pulse
        bus_wait = 3;
        bq.push_back(mk(0, 32'h600, 32'h0, 4'h0));
        fq.push_back(32'h600);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ext_valid) begin seen = 1; break; end
        end
        check("t5_granted", 32'(seen), 32'h1);
        abandon_fetch = 1;
        wait_done("t5_done");
        check("t5_state_idle", 32'(dut.state_q), 32'h0);

        // reset during a stalled data transaction
        bus_wait = 20;
        bq.push_back(mk(1, 32'h6000, 32'h7777_8888, 4'hC));
        mq.push_back(mk(1, 32'h6000, 32'h7777_8888, 4'hC));
        fq.push_back(32'h700);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ext_valid) begin seen = 1; break; end
        end
        check("t6_granted", 32'(seen), 32'h1);
        check("t6_streak_before", 32'(dut.streak_q), 32'h1);
        @(posedge clk); #1;
        reset = 1;
        mq.delete();
        fq.delete();
        @(posedge clk); #1;
        bq.delete();
        check("t6_ext_valid", 32'(ext_valid), 32'h0);
        check("t6_state", 32'(dut.state_q), 32'h0);
        check("t6_streak", 32'(dut.streak_q), 32'h0);
        check("t6_readys", {30'h0, fetch_ready, mem_ready}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 0;
        exp_last_load = 32'h0;
        check("t6_mem_rdata", mem_rdata, 32'h0);

        // clean load after reset
        bus_wait = 1;
        bq.push_back(mk(0, 32'h8000, 32'h0, 4'h0));
        rq.push_back(rs(0, 32'hC0DE_8000));
        mq.push_back(mk(0, 32'h8000, 32'h0, 4'h0));
        wait_done("t7_done");

        check("end_bus_queue", 32'(bq.size()), 32'h0);
        check("end_resp_queue", 32'(rq.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
